mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Control stage for the repeated-addition multiplier datapath. It sequences operand loads and owns the multiplier down-counter.
- It drives ld_p/clr_p of the 16-bit product register downstream. That register gives load priority over clear, has no reset, and accumulates P <= P + A when ld_p is asserted.
- It also drives the load enables of the A and B operand registers.
- It produces P = A × B by adding A into P exactly B times, then signals done.

Parameters:
- WIDTH, 16, operand/counter width; must match the datapath register width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- data_in  input  WIDTH  operand bus; carries A in LOAD_A, B in LOAD_B
- ld_a  output  1  load enable to the A operand register
- ld_b  output  1  load enable to the B operand register
- ld_p  output  1  product register load (accumulate) enable
- clr_p  output  1  product register synchronous clear
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: product register holds final result
- count  output  WIDTH  remaining additions (debug/observe)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, count=0. All outputs 0. Reset dominates everything.
- Reset does not touch the product register; the next run clears it in LOAD_B.
- Outputs are Moore, decoded from the registered state only. No output depends combinationally on start or data_in.
- States and transitions:
  - IDLE: all outputs 0. start=1 → LOAD_A; else stay.
  - LOAD_A: ld_a=1, busy=1. Always → LOAD_B.
  - LOAD_B: ld_b=1, clr_p=1, busy=1. count <= data_in. If data_in==0 → DONE; else → ADD.
  - ADD: ld_p=1, busy=1. count <= count-1. If count==1 → DONE; else stay.
  - DONE: done=1, busy=1, count holds 0. Always → IDLE.
- Cycle timing, with start sampled at edge 0:
  - LOAD_A occupies cycle 1, LOAD_B cycle 2.
  - ADD occupies cycles 3..2+B, i.e. exactly B ld_p pulses.
  - DONE occupies cycle 3+B (cycle 3 when B=0).
  - Total latency from start to done: B+3 cycles.
- ld_p and clr_p are never high in the same cycle. The downstream register gives ld priority, so overlap would corrupt the clear.
- At most one of ld_a, ld_b, ld_p, clr_p is a load enable per cycle, except that ld_b and clr_p are both high in LOAD_B.
- start while busy: ignored, not queued.
- start held high through DONE: IDLE samples it on the following edge and begins a new run. Back-to-back runs have one IDLE cycle between done and the next ld_a.
- Counter uses unsigned WIDTH-bit arithmetic. It never decrements below 0, because ADD is never entered with count==0.
- B = 2^WIDTH-1 is legal and gives 2^WIDTH-1 ld_p pulses.
- Product overflow beyond WIDTH bits wraps in the datapath; the controller does not detect it.
- data_in is don't-care outside LOAD_A and LOAD_B.

Test Plan:
- Reset, then start=1 for one cycle with data_in=5 in LOAD_A and 3 in LOAD_B:
  - ld_a high cycle 1; ld_b+clr_p high cycle 2.
  - ld_p high cycles 3–5; done high cycle 6 only.
  - With the datapath attached, P=15.
- A=7, B=0: clr_p in cycle 2, zero ld_p pulses, done in cycle 3, P=0.
- A=9, B=1: exactly one ld_p (cycle 3), done in cycle 4, P=9.
- Pulse start again during ADD (A=4, B=4): no restart, and count keeps decrementing 4→3→2→1→0. After done, start held high begins a second run with ld_a one cycle after IDLE.
- Assert rst_n=0 mid-ADD (A=2, B=10, after 3 ld_p):
  - All outputs go 0 immediately, asynchronously; state=IDLE; count=0.
  - A fresh run with A=3, B=2 gives P=6, proving clr_p recovery.
- Assertion over all tests: never (ld_p && clr_p); done only ever a 1-cycle pulse; busy==0 only in IDLE.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Control stage of a repeated-addition multiplier. It sequences the loads
//   of the A and B operand registers and owns the multiplier down-counter.
//   It clears the product register, then pulses ld_p once per remaining
//   addition, so the datapath computes P = A * B by adding A into P B times.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   multiply request, sampled only in IDLE
//   data_in    in   [WIDTH] operand bus: A during LOAD_A, B during LOAD_B
//   ld_a       out  A operand register load enable
//   ld_b       out  B operand register load enable
//   ld_p       out  product register accumulate enable (P <= P + A)
//   clr_p      out  product register synchronous clear
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, product register holds the result
//   count      out  [WIDTH] remaining additions
//   state_dbg  out  [3] current FSM state, for observation only
//
// Handshake: start is a level request with no ready. It is looked at only in
// IDLE; while busy it is ignored and not queued. A start still high in the
// IDLE cycle after done begins a new run on the next edge.
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_p,
  output logic             clr_p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic ld_a_q,  ld_a_d;
  logic ld_b_q,  ld_b_d;
  logic ld_p_q,  ld_p_d;
  logic clr_p_q, clr_p_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;

  // Next state and counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        count_d = data_in;
        // B == 0 skips ADD entirely, so the counter is never decremented
        // from zero.
        state_d = (data_in == '0) ? S_DONE : S_ADD;
      end
      S_ADD: begin
        count_d = count_q - WIDTH'(1);
        if (count_q == WIDTH'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // register holds exactly the Moore decode of state_q. ld_p and clr_p come
  // from different states and can never be high together, which matters
  // because the product register lets a load win over a clear.
  always_comb begin
    ld_a_d  = 1'b0;
    ld_b_d  = 1'b0;
    ld_p_d  = 1'b0;
    clr_p_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_LOAD_A: ld_a_d = 1'b1;
      S_LOAD_B: begin
        ld_b_d  = 1'b1;
        clr_p_d = 1'b1;
      end
      S_ADD:    ld_p_d = 1'b1;
      S_DONE:   done_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      ld_p_q  <= 1'b0;
      clr_p_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ld_a_q  <= ld_a_d;
      ld_b_q  <= ld_b_d;
      ld_p_q  <= ld_p_d;
      clr_p_q <= clr_p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ld_a      = ld_a_q;
  assign ld_b      = ld_b_q;
  assign ld_p      = ld_p_q;
  assign clr_p     = clr_p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Drives mult_seq_ctrl with directed and randomized multiplies. A small
//   product/operand datapath is attached so the final P can be compared with
//   A*B. Expected per-cycle outputs come from the cycle timeline of a run:
//   LOAD_A in cycle 1, LOAD_B in cycle 2, ADD in cycles 3..2+B, DONE in
//   cycle 3+B, IDLE afterwards, where cycle 1 follows the edge sampling start.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int WIDTH = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             ld_a, ld_b, ld_p, clr_p, busy, done;
  logic [WIDTH-1:0] count;
  logic [2:0]       state_dbg;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_p      (ld_p),
    .clr_p     (clr_p),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // Downstream datapath: operand registers and a reset-less product register
  // where load has priority over clear.
  logic [WIDTH-1:0] a_r, b_r, p_r;
  always @(posedge clk) begin
    if (ld_a) a_r <= data_in;
    if (ld_b) b_r <= data_in;
    if (ld_p)       p_r <= p_r + a_r;
    else if (clr_p) p_r <= '0;
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference timeline: flags are {ld_a, ld_b, ld_p, clr_p, busy, done}.
  function automatic logic [5:0] exp_flags(input int k, input int b);
    if (k == 1)                 return 6'b100010;
    else if (k == 2)            return 6'b010110;
    else if (k >= 3 && k <= 2 + b) return 6'b001010;
    else if (k == 3 + b)        return 6'b000011;
    else                        return 6'b000000;
  endfunction

  // Remaining additions seen in cycle k: B at the first ADD cycle, one less
  // each cycle after, 0 in DONE; 0 before LOAD_B has taken effect.
  function automatic int exp_count(input int k, input int b);
    if (k <= 2)          return 0;
    else if (k <= 3 + b) return b - (k - 3);
    else                 return 0;
  endfunction

  // Protocol monitor sampled on the falling edge.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    check("no_ldp_with_clrp", 32'(ld_p & clr_p), 32'd0);
    if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
    if (!busy) check("idle_outputs_quiet", 32'({ld_a, ld_b, ld_p, clr_p, done}), 32'd0);
    prev_done = done;
  end

  // Driver: entered #1 after a posedge with the DUT in IDLE for this cycle.
  // pulse_k re-asserts start in that cycle (ignored while busy); hold keeps
  // start high from DONE on so the next run chains.
  task automatic run_mult(input int a, input int b, input int pulse_k, input bit hold);
    logic [5:0] f;
    int exp_p;
    start   = 1'b1;
    data_in = WIDTH'($urandom);
    exp_p   = (a * b) & 32'hFFFF;
    for (int k = 1; k <= b + 3; k++) begin
      @(posedge clk);
      #1;
      start = (k == pulse_k) || (hold && k == b + 3);
      if (k == 1)      data_in = WIDTH'(a);
      else if (k == 2) data_in = WIDTH'(b);
      else             data_in = WIDTH'($urandom);
      f = exp_flags(k, b);
      check($sformatf("flags a=%0d b=%0d cyc=%0d", a, b, k),
            32'({ld_a, ld_b, ld_p, clr_p, busy, done}), 32'(f));
      check($sformatf("count a=%0d b=%0d cyc=%0d", a, b, k),
            32'(count), 32'(exp_count(k, b)));
      if (k == b + 3)
        check($sformatf("product a=%0d b=%0d", a, b), 32'(p_r), 32'(exp_p));
    end
    @(posedge clk);
    #1;
    check($sformatf("idle_after a=%0d b=%0d", a, b),
          32'({ld_a, ld_b, ld_p, clr_p, busy, done}), 32'd0);
    check($sformatf("idle_count a=%0d b=%0d", a, b), 32'(count), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({ld_a, ld_b, ld_p, clr_p, busy, done}), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed runs
    run_mult(5, 3, 0, 1'b0);
    run_mult(7, 0, 0, 1'b0);
    run_mult(9, 1, 0, 1'b0);
    run_mult(4, 4, 4, 1'b1);   // start pulse mid-ADD, then held into a new run
    run_mult(6, 2, 0, 1'b0);

    // Asynchronous reset in the middle of ADD after three ld_p pulses
    start   = 1'b1;
    data_in = WIDTH'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 1)      data_in = WIDTH'(2);
      else if (k == 2) data_in = WIDTH'(10);
      else             data_in = WIDTH'($urandom);
      check($sformatf("flags pre_reset cyc=%0d", k),
            32'({ld_a, ld_b, ld_p, clr_p, busy, done}), 32'(exp_flags(k, 10)));
      check($sformatf("count pre_reset cyc=%0d", k), 32'(count), 32'(exp_count(k, 10)));
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", 32'({ld_a, ld_b, ld_p, clr_p, busy, done}), 32'd0);
    check("async_reset_count", 32'(count), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_mult(3, 2, 0, 1'b0);   // product register recovers through clr_p

    // Randomized runs
    for (int i = 0; i < 8; i++) begin
      int a, b;
      a = int'($urandom_range(0, 65535));
      b = (i == 7) ? int'($urandom_range(200, 400)) : int'($urandom_range(0, 25));
      run_mult(a, b, (b > 2) ? int'($urandom_range(3, b + 2)) : 0, (i % 3) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
